// File: rtl/i2s_pkg.sv
// Shared I2S constants: data-controller FSM encodings and the BYTE_SIZE config field.
package i2s_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_FETCH = 3'd1,
      ST_WAIT  = 3'd2,
      ST_LOAD  = 3'd3,
      ST_SEND  = 3'd4
   } state_e;

   localparam int unsigned BYTE_SIZE_LSB     = 8;
   localparam int unsigned BYTE_SIZE_MSB     = 11;
   localparam int unsigned BYTE_SIZE_W       = BYTE_SIZE_MSB - BYTE_SIZE_LSB + 1;
   localparam int unsigned BYTE_SIZE_DEFAULT = 4;
   localparam int unsigned NBYTES_W          = 3;

   // Out-of-range byte counts (0 or above 4) fall back to a full 4-byte sample.
   function automatic logic [NBYTES_W-1:0] byte_size_sanitize(input logic [BYTE_SIZE_W-1:0] field);
      if (field == '0 || field > BYTE_SIZE_W'(BYTE_SIZE_DEFAULT))
         return NBYTES_W'(BYTE_SIZE_DEFAULT);
      return NBYTES_W'(field);
   endfunction

endpackage

// File: rtl/i2s_rx_data_ctrl.sv
// I2S receive data controller: pops 32-bit samples and writes their top 1-4 bytes,
// MSB first, into the host PHY read FIFO.
module i2s_rx_data_ctrl
   import i2s_pkg::*;
#(
   parameter int unsigned DATA_WIDTH        = 32,
   parameter int unsigned CONFIG_DATA_WIDTH = 40,
   parameter int unsigned PHY_FIFO_WIDTH    = 8
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic [CONFIG_DATA_WIDTH-1:0] config_data,
   input  logic                         config_write,
   input  logic                         s_empty,
   output logic                         s_read_en,
   input  logic [DATA_WIDTH-1:0]        s_read_data,
   input  logic                         f_full,
   output logic                         fifo_write_en,
   output logic [PHY_FIFO_WIDTH-1:0]    fifo_write_data,
   output logic                         busy
);

   state_e                      state, state_nxt;
   logic [BYTE_SIZE_W-1:0]      cfg_field_q;
   logic                        cfg_pend_q;
   logic [NBYTES_W-1:0]         byte_size_q;
   logic [NBYTES_W-1:0]         nbytes_q, nbytes_nxt;
   logic [NBYTES_W-1:0]         idx_q, idx_nxt;
   logic [DATA_WIDTH-1:0]       shreg_q, shreg_nxt;
   logic                        s_read_en_nxt, wr_en_nxt, busy_nxt;
   logic [PHY_FIFO_WIDTH-1:0]   wr_data_nxt;
   logic                        cfg_unused;

   assign cfg_unused = ^{config_data[CONFIG_DATA_WIDTH-1:BYTE_SIZE_MSB+1],
                         config_data[BYTE_SIZE_LSB-1:0]};

   // Next state, serialiser and registered-output inputs.
   always_comb begin
      state_nxt   = state;
      shreg_nxt   = shreg_q;
      nbytes_nxt  = nbytes_q;
      idx_nxt     = idx_q;
      wr_en_nxt   = 1'b0;
      wr_data_nxt = fifo_write_data;
      case (state)
         ST_IDLE:  if (!s_empty) state_nxt = ST_FETCH;
         ST_FETCH: state_nxt = ST_WAIT;
         ST_WAIT:  state_nxt = ST_LOAD;
         ST_LOAD: begin
            shreg_nxt  = s_read_data;
            nbytes_nxt = byte_size_q;
            idx_nxt    = '0;
            state_nxt  = ST_SEND;
         end
         ST_SEND: begin
            if (!f_full) begin
               wr_en_nxt   = 1'b1;
               wr_data_nxt = shreg_q[DATA_WIDTH-1 -: PHY_FIFO_WIDTH];
               shreg_nxt   = shreg_q << PHY_FIFO_WIDTH;
               idx_nxt     = idx_q + NBYTES_W'(1);
               if (idx_q == nbytes_q - NBYTES_W'(1)) state_nxt = ST_IDLE;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
      s_read_en_nxt = (state_nxt == ST_FETCH);
      busy_nxt      = (state_nxt != ST_IDLE);
   end

   // Config is staged one cycle, so a strobe coincident with LOAD is not yet visible.
   always_ff @(posedge clk) begin
      if (reset) begin
         state           <= ST_IDLE;
         cfg_field_q     <= '0;
         cfg_pend_q      <= 1'b0;
         byte_size_q     <= NBYTES_W'(BYTE_SIZE_DEFAULT);
         nbytes_q        <= '0;
         idx_q           <= '0;
         shreg_q         <= '0;
         s_read_en       <= 1'b0;
         fifo_write_en   <= 1'b0;
         fifo_write_data <= '0;
         busy            <= 1'b0;
      end else begin
         state           <= state_nxt;
         cfg_pend_q      <= config_write;
         if (config_write) cfg_field_q <= config_data[BYTE_SIZE_MSB:BYTE_SIZE_LSB];
         if (cfg_pend_q)   byte_size_q <= byte_size_sanitize(cfg_field_q);
         nbytes_q        <= nbytes_nxt;
         idx_q           <= idx_nxt;
         shreg_q         <= shreg_nxt;
         s_read_en       <= s_read_en_nxt;
         fifo_write_en   <= wr_en_nxt;
         fifo_write_data <= wr_data_nxt;
         busy            <= busy_nxt;
      end
   end

endmodule

// File: tb/tb_i2s_rx_data_ctrl.sv
// Self-checking bench for i2s_rx_data_ctrl: vector table, directed corner cases and
// randomized samples/backpressure checked against a byte-stream model.
module tb_i2s_rx_data_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic [39:0] config_data;
   logic        config_write;
   logic        s_empty;
   logic        s_read_en;
   logic [31:0] s_read_data;
   logic        f_full;
   logic        fifo_write_en;
   logic [7:0]  fifo_write_data;
   logic        busy;

   i2s_rx_data_ctrl dut (
      .clk(clk), .reset(reset), .config_data(config_data), .config_write(config_write),
      .s_empty(s_empty), .s_read_en(s_read_en), .s_read_data(s_read_data),
      .f_full(f_full), .fifo_write_en(fifo_write_en), .fifo_write_data(fifo_write_data),
      .busy(busy)
   );

   always #5 clk = ~clk;

   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   int          viol = 0;
   int          rd_cnt = 0;
   bit          rand_full = 0;
   logic [31:0] sq[$];
   logic [7:0]  out_q[$];
   int          wr_cyc[$];
   logic [7:0]  exp_q[$];

   typedef struct {
      logic [3:0]  bs;
      logic [31:0] sample;
      int          n;
      logic [31:0] exp;
   } vec_t;
   vec_t vecs[6];

   // Sample-FIFO model plus output monitor, both acting 1ns after the clock edge.
   always @(posedge clk) begin
      logic rd, ff;
      cyc++;
      rd = s_read_en;
      ff = f_full;
      #1;
      if (rd) begin
         rd_cnt++;
         if (sq.size() == 0) viol++;
         else s_read_data = sq.pop_front();
         s_empty = (sq.size() == 0);
      end
      if (fifo_write_en) begin
         out_q.push_back(fifo_write_data);
         wr_cyc.push_back(cyc);
         if (ff) viol++;
      end
   end

   always @(negedge clk) if (rand_full) f_full = ($urandom_range(0, 2) == 0);

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic push(input logic [31:0] s);
      sq.push_back(s);
      s_empty = 1'b0;
   endtask

   task automatic cfg(input logic [3:0] bs);
      logic [39:0] w;
      w = {8'($urandom), 32'($urandom)};
      w[11:8] = bs;
      config_data  = w;
      config_write = 1'b1;
      @(negedge clk);
      config_write = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   task automatic clear_obs();
      out_q.delete();
      wr_cyc.delete();
      exp_q.delete();
   endtask

   task automatic wait_done(input string name);
      int n;
      n = 0;
      @(negedge clk);
      while ((sq.size() != 0 || busy) && n < 3000) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (n >= 3000) begin
         errors++;
         $display("FAIL %s_timeout: got busy after %0d cycles expected idle", name, n);
      end
      repeat (3) @(negedge clk);
   endtask

   task automatic wait_writes(input int k);
      int n;
      n = 0;
      while (out_q.size() < k && n < 200) begin
         @(negedge clk);
         n++;
      end
   endtask

   task automatic compare(input string name);
      chk($sformatf("%s_count", name), 32'(out_q.size()), 32'(exp_q.size()));
      for (int i = 0; i < out_q.size() && i < exp_q.size(); i++)
         chk($sformatf("%s_byte%0d", name, i), 32'(out_q[i]), 32'(exp_q[i]));
   endtask

   task automatic push_exp_top(input logic [31:0] s, input int n);
      for (int j = 0; j < n; j++) exp_q.push_back(s[31-8*j -: 8]);
   endtask

   initial begin
      logic [31:0] w, smp;
      logic [3:0]  bs;
      int          t0, r0, n;

      vecs[0] = '{4'd4, 32'hA1B2C3D4, 4, 32'hA1B2C3D4};
      vecs[1] = '{4'd2, 32'h12345678, 2, 32'h12340000};
      vecs[2] = '{4'd0, 32'h0F1E2D3C, 4, 32'h0F1E2D3C};
      vecs[3] = '{4'd9, 32'h55AA33CC, 4, 32'h55AA33CC};
      vecs[4] = '{4'd1, 32'hCAFEBABE, 1, 32'hCA000000};
      vecs[5] = '{4'd3, 32'hDEADBEEF, 3, 32'hDEADBE00};

      reset = 1'b1; config_data = '0; config_write = 1'b0;
      s_empty = 1'b1; s_read_data = '0; f_full = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_s_read_en", 32'(s_read_en), 0);
      chk("rst_wr_en", 32'(fifo_write_en), 0);
      chk("rst_wr_data", 32'(fifo_write_data), 0);
      chk("rst_busy", 32'(busy), 0);
      reset = 1'b0;
      repeat (2) @(negedge clk);

      // Default 4-byte mode: latency, back-to-back bytes, busy drop.
      clear_obs();
      t0 = cyc;
      push(32'hA1B2C3D4);
      wait_writes(1);
      chk("basic_busy_during", 32'(busy), 1);
      wait_done("basic");
      push_exp_top(32'hA1B2C3D4, 4);
      compare("basic");
      if (wr_cyc.size() == 4) begin
         chk("basic_latency", 32'(wr_cyc[0] - (t0 + 1)), 4);
         for (int i = 1; i < 4; i++) chk($sformatf("basic_consec%0d", i), 32'(wr_cyc[i] - wr_cyc[0]), 32'(i));
      end
      chk("basic_busy_after", 32'(busy), 0);

      for (int i = 0; i < 6; i++) begin
         cfg(vecs[i].bs);
         clear_obs();
         push(vecs[i].sample);
         wait_done($sformatf("vec%0d", i));
         w = vecs[i].exp;
         push_exp_top(w, vecs[i].n);
         compare($sformatf("vec%0d", i));
      end

      // 16-bit mode, two samples, two pops.
      cfg(4'd2);
      clear_obs();
      r0 = rd_cnt;
      push(32'h12345678);
      push(32'h9ABCDEF0);
      wait_done("mode16");
      exp_q = '{8'h12, 8'h34, 8'h9A, 8'hBC};
      compare("mode16");
      chk("mode16_pops", 32'(rd_cnt - r0), 2);

      // Backpressure for three cycles after the first byte.
      cfg(4'd4);
      clear_obs();
      push(32'h11223344);
      wait_writes(1);
      f_full = 1'b1;
      repeat (3) @(negedge clk);
      f_full = 1'b0;
      wait_done("bp");
      exp_q = '{8'h11, 8'h22, 8'h33, 8'h44};
      compare("bp");
      if (wr_cyc.size() >= 2) chk("bp_gap", 32'(wr_cyc[1] - wr_cyc[0]), 4);

      // Config change mid-sample only affects the following sample.
      clear_obs();
      push(32'h55667788);
      push(32'hCAFEBABE);
      wait_writes(1);
      config_data = 40'h00_0000_0100;
      config_write = 1'b1;
      @(negedge clk);
      config_write = 1'b0;
      wait_done("midcfg");
      exp_q = '{8'h55, 8'h66, 8'h77, 8'h88, 8'hCA};
      compare("midcfg");

      // Reset after two bytes; reset also restores the 4-byte default.
      cfg(4'd3);
      clear_obs();
      push(32'hDEADBEEF);
      wait_writes(2);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("rstmid_s_read_en", 32'(s_read_en), 0);
      chk("rstmid_wr_en", 32'(fifo_write_en), 0);
      chk("rstmid_wr_data", 32'(fifo_write_data), 0);
      chk("rstmid_busy", 32'(busy), 0);
      repeat (4) @(negedge clk);
      push(32'h01020304);
      wait_done("rstmid");
      exp_q = '{8'hDE, 8'hAD, 8'h01, 8'h02, 8'h03, 8'h04};
      compare("rstmid");

      // Loopback: bytes packed three per sample by a TX-side model, random backpressure.
      cfg(4'd3);
      clear_obs();
      rand_full = 1;
      for (int s = 0; s < 34; s++) begin
         smp = $urandom;
         for (int j = 0; j < 3; j++) exp_q.push_back(smp[31-8*j -: 8]);
         push(smp);
      end
      wait_done("loop");
      rand_full = 0;
      f_full = 1'b0;
      compare("loop");

      // Random byte sizes, samples and backpressure.
      for (int it = 0; it < 15; it++) begin
         bs = 4'($urandom_range(0, 15));
         n  = (bs == 0 || bs > 4) ? 4 : int'(bs);
         cfg(bs);
         clear_obs();
         rand_full = 1;
         for (int k = 0; k < int'($urandom_range(1, 3)); k++) begin
            smp = $urandom;
            push_exp_top(smp, n);
            push(smp);
         end
         wait_done($sformatf("rnd%0d", it));
         rand_full = 0;
         f_full = 1'b0;
         compare($sformatf("rnd%0d", it));
      end

      chk("protocol_violations", 32'(viol), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
